// File: rtl/adder_seq_arb.sv
// Two-requester round-robin adder that serialises each addition through a single
// 8-bit full-adder slice, one byte per cycle. Define ADDSEQ_OVF_EN to add rsp_ovf.
module adder_seq_arb #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_x,
    input  logic [8*NBYTES-1:0]   req0_y,
    input  logic                  req0_cin,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_x,
    input  logic [8*NBYTES-1:0]   req1_y,
    input  logic                  req1_cin,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [8*NBYTES-1:0]   rsp_s,
`ifdef ADDSEQ_OVF_EN
    output logic                  rsp_ovf,
`endif
    output logic                  rsp_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic            last_grant_reg;
    logic            grant;
    logic            accept;

    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic            carry_reg;
    logic            id_reg;
    logic            cout_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      sum_bytes_reg [NBYTES];

    logic [7:0]      x_byte [NBYTES];
    logic [7:0]      y_byte [NBYTES];
    logic [7:0]      slice_x;
    logic [7:0]      slice_y;
    logic [8:0]      slice_sum;
    logic            last_byte;

    // Byte lanes of the latched operands and of the assembled result.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign x_byte[gi]           = x_reg[8*gi +: 8];
            assign y_byte[gi]           = y_reg[8*gi +: 8];
            assign rsp_s[8*gi +: 8]     = sum_bytes_reg[gi];
        end
    endgenerate

    // The one and only full-adder slice.
    assign slice_x   = x_byte[cnt_reg];
    assign slice_y   = y_byte[cnt_reg];
    assign slice_sum = {1'b0, slice_x} + {1'b0, slice_y} + {8'd0, carry_reg};
    assign last_byte = (cnt_reg == CW'(NBYTES - 1));

    assign rsp_valid = (state_reg == DONE);
    assign rsp_id    = id_reg;
    assign rsp_cout  = cout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        // Contention goes to whoever was not granted last; otherwise the lone requester.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else begin
            grant = req1_valid;
        end
        case (state_reg)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            x_reg          <= '0;
            y_reg          <= '0;
            carry_reg      <= 1'b0;
            id_reg         <= 1'b0;
            cout_reg       <= 1'b0;
            cnt_reg        <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                sum_bytes_reg[i] <= 8'd0;
            end
        end else if (accept) begin
            last_grant_reg <= grant;
            x_reg          <= grant ? req1_x   : req0_x;
            y_reg          <= grant ? req1_y   : req0_y;
            carry_reg      <= grant ? req1_cin : req0_cin;
            id_reg         <= grant;
            cnt_reg        <= '0;
        end else if (state_reg == ADD) begin
            sum_bytes_reg[cnt_reg] <= slice_sum[7:0];
            carry_reg              <= slice_sum[8];
            if (last_byte) begin
                cout_reg <= slice_sum[8];
                cnt_reg  <= '0;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
            end
        end
    end

`ifdef ADDSEQ_OVF_EN
    logic ovf_reg;
    logic msb_carry_in;

    // Carry into bit 7 of the slice, recovered from the sum bit.
    assign msb_carry_in = slice_x[7] ^ slice_y[7] ^ slice_sum[7];
    assign rsp_ovf      = ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ADD && last_byte) begin
            ovf_reg <= msb_carry_in ^ slice_sum[8];
        end
    end
`endif

endmodule

// File: tb/tb_adder_seq_arb.sv
// Randomised self-checking bench for adder_seq_arb (NBYTES=4) against a
// plain-arithmetic model of arbitration, latency and the wide addition.
module tb_adder_seq_arb;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_cin;
    logic [W-1:0]  req0_x, req0_y;
    logic          req1_valid, req1_ready, req1_cin;
    logic [W-1:0]  req1_x, req1_y;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0]  rsp_s;
`ifdef ADDSEQ_OVF_EN
    logic          rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;
    bit last_g;          // model of the round-robin pointer
    bit gq[$];

    always #5 clk = ~clk;

    adder_seq_arb #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
`ifdef ADDSEQ_OVF_EN
        .rsp_ovf(rsp_ovf),
`endif
        .rsp_cout(rsp_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_operands();
        req0_x = $urandom; req0_y = $urandom; req0_cin = 1'($urandom);
        req1_x = $urandom; req1_y = $urandom; req1_cin = 1'($urandom);
    endtask

    // Present one transaction from the IDLE cycle, follow it to the handshake.
    task automatic do_op(input bit v0, input bit v1,
                         input logic [W-1:0] x0, input logic [W-1:0] y0, input bit c0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1, input bit c1,
                         input int bp, output bit g);
        logic [W:0]   full;
        logic [W-1:0] ex, ey, es;
        bit           ecout, eovf;
        int           waited, lat;
        req0_valid = v0; req0_x = x0; req0_y = y0; req0_cin = c0;
        req1_valid = v1; req1_x = x1; req1_y = y1; req1_cin = c1;
        rsp_ready  = 1'b0;
        #1;
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        waited = 0;
        while (!(req0_ready || req1_ready) && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check("grant_wait", 64'(waited), 64'd0);
        g = (v0 && v1) ? ~last_g : v1;
        check("grant", 64'({req1_ready, req0_ready}), g ? 64'd2 : 64'd1);
        last_g = g;
        ex    = g ? x1 : x0;
        ey    = g ? y1 : y0;
        full  = {1'b0, ex} + {1'b0, ey} + (W+1)'(g ? c1 : c0);
        es    = full[W-1:0];
        ecout = full[W];
        eovf  = (ex[W-1] == ey[W-1]) && (es[W-1] != ex[W-1]);
        lat = 0;
        do begin
            @(negedge clk);
            scramble_operands();
            lat++;
            #1;
            check("busy_ready", 64'({req1_ready, req0_ready}), 64'd0);
        end while (!rsp_valid && lat < 20);
        check("latency", 64'(lat), 64'(NB + 1));
        for (int i = 0; i <= bp; i++) begin
            if (i == bp) begin
                rsp_ready = 1'b1;
                #1;
            end
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_s", 64'(rsp_s), 64'(es));
            check("rsp_cout", 64'(rsp_cout), 64'(ecout));
            check("rsp_id", 64'(rsp_id), 64'(g));
`ifdef ADDSEQ_OVF_EN
            check("rsp_ovf", 64'(rsp_ovf), 64'(eovf));
`endif
            check("done_ready", 64'({req1_ready, req0_ready}), 64'd0);
            $display("op id=%0d x=%08h y=%08h s=%08h cout=%0d ovf=%0d bp_cycle=%0d", g, ex, ey, rsp_s, rsp_cout, eovf, i);
            @(negedge clk);
            if (i != bp) begin
                scramble_operands();
                #1;
            end
        end
    endtask

    initial begin
        bit g;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_x = 0; req0_y = 0; req0_cin = 0; req1_x = 0; req1_y = 0; req1_cin = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_s", 64'(rsp_s), 64'd0);
        check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        last_g = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesters valid from reset for three operations.
        for (int k = 0; k < 3; k++) begin
            do_op(1, 1, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 0, g);
            gq.push_back(g);
        end
        check("rr_order0", 64'(gq[0]), 64'd0);
        check("rr_order1", 64'(gq[1]), 64'd1);
        check("rr_order2", 64'(gq[2]), 64'd0);

        do_op(1, 0, 32'h0000_00FF, 32'h0000_0001, 0, 0, 0, 0, 0, g);
        do_op(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, g);
        do_op(1, 1, $urandom, $urandom, 0, $urandom, $urandom, 1, 5, g);
`ifdef ADDSEQ_OVF_EN
        do_op(1, 0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 0, g);
        do_op(1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 0, g);
`endif

        // Reset during byte 2 of an addition; no stale response afterwards.
        req0_valid = 1; req1_valid = 0; req0_x = 32'h1234_5678; req0_y = 32'h1111_1111; req0_cin = 0;
        rsp_ready = 1'b1;
        #1;
        check("pre_rst_grant", 64'({req1_ready, req0_ready}), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_s", 64'(rsp_s), 64'd0);
        check("mid_rst_cout", 64'(rsp_cout), 64'd0);
        check("mid_rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        $display("reset asserted mid-operation: rsp_s=%08h", rsp_s);
        @(negedge clk);
        rst_n = 1'b1;
        last_g = 1'b1;
        do_op(1, 0, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 0, 0, g);

        for (int k = 0; k < 24; k++) begin
            int v;
            v = $urandom_range(1, 3);
            do_op(v[0], v[1], $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom),
                  $urandom_range(0, 3), g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
